// File: rtl/pulse_monitor.sv
// pulse_monitor
// Measures the interval in clk cycles between consecutive rising edges of
// pulse_in, flags intervals that deviate from the nominal delay by more than
// tol, detects loss of the stream when no edge arrives within 2*delay cycles,
// and reports lock once four consecutive in-tolerance periods were measured.
//
// Ports
//   clk           in   single clock, rising edge
//   reset         in   synchronous active-high reset
//   pulse_in      in   monitored pulse stream, synchronous to clk
//   period        out  last measured edge-to-edge interval [cnt_w]
//   period_valid  out  one-cycle strobe: period was updated
//   period_err    out  last measured period out of tolerance
//   lost          out  no edge within 2*delay cycles
//   locked        out  four consecutive in-tolerance periods
//   edge_cnt      out  rising edges since reset, saturating [16]
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | after reset, waiting for the first edge (no reference yet)
// MEASURE  | counting cycles since the last edge; next edge yields a period
// LOST     | timeout hit; next edge restarts timing without a period

module pulse_monitor #(
    parameter int unsigned delay = 3,
    parameter int unsigned tol   = 0,
    parameter int unsigned cnt_w = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pulse_in,
    output logic [cnt_w-1:0] period,
    output logic             period_valid,
    output logic             period_err,
    output logic             lost,
    output logic             locked,
    output logic [15:0]      edge_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MEASURE = 2'd1,
        ST_LOST    = 2'd2
    } state_t;

    localparam logic [cnt_w-1:0] CNT_MAX   = '1;
    localparam logic [cnt_w-1:0] CNT_ONE   = cnt_w'(1);
    localparam logic [cnt_w-1:0] TWO_DELAY = cnt_w'(2 * delay);
    localparam logic [cnt_w:0]   DELAY_X   = (cnt_w + 1)'(delay);
    localparam logic [cnt_w:0]   TOL_X     = (cnt_w + 1)'(tol);
    localparam logic [2:0]       RUN_LOCK  = 3'd4;

    state_t           state_q, state_d;
    logic [cnt_w-1:0] cnt_q, cnt_d;
    logic [2:0]       good_run_q, good_run_d;
    logic [cnt_w-1:0] period_q, period_d;
    logic             period_valid_q, period_valid_d;
    logic             period_err_q, period_err_d;
    logic             lost_q, lost_d;
    logic             locked_q, locked_d;
    logic [15:0]      edge_cnt_q, edge_cnt_d;
    logic             pulse_q, pulse_d;

    logic             edge_det;
    logic [cnt_w:0]   cnt_x;
    logic [cnt_w:0]   diff;
    logic             in_tol;

    assign edge_det = pulse_in & ~pulse_q;
    assign pulse_d  = pulse_in;

    // One extra bit so the absolute deviation never wraps.
    assign cnt_x  = {1'b0, cnt_q};
    assign diff   = (cnt_x >= DELAY_X) ? (cnt_x - DELAY_X) : (DELAY_X - cnt_x);
    assign in_tol = (diff <= TOL_X);

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        good_run_d     = good_run_q;
        period_d       = period_q;
        period_valid_d = 1'b0;
        period_err_d   = period_err_q;
        lost_d         = lost_q;
        edge_cnt_d     = edge_cnt_q;

        if (edge_det && (edge_cnt_q != 16'hFFFF)) begin
            edge_cnt_d = edge_cnt_q + 16'd1;
        end

        case (state_q)
            ST_IDLE: begin
                if (edge_det) begin
                    state_d = ST_MEASURE;
                    cnt_d   = CNT_ONE;
                end
            end
            ST_MEASURE: begin
                // An edge coinciding with the timeout still counts as a period.
                if (edge_det) begin
                    period_d       = cnt_q;
                    period_valid_d = 1'b1;
                    period_err_d   = ~in_tol;
                    cnt_d          = CNT_ONE;
                    if (!in_tol) begin
                        good_run_d = 3'd0;
                    end else if (good_run_q != RUN_LOCK) begin
                        good_run_d = good_run_q + 3'd1;
                    end
                end else if (cnt_q == TWO_DELAY) begin
                    state_d    = ST_LOST;
                    lost_d     = 1'b1;
                    good_run_d = 3'd0;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_LOST: begin
                // The gap before this edge is not a meaningful period.
                if (edge_det) begin
                    state_d = ST_MEASURE;
                    cnt_d   = CNT_ONE;
                    lost_d  = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        locked_d = (good_run_d == RUN_LOCK);
    end

    always_ff @(posedge clk) begin
        // Tracks the input even in reset so a level held high across
        // release is not seen as an edge.
        pulse_q <= pulse_d;
        if (reset) begin
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            good_run_q     <= 3'd0;
            period_q       <= '0;
            period_valid_q <= 1'b0;
            period_err_q   <= 1'b0;
            lost_q         <= 1'b0;
            locked_q       <= 1'b0;
            edge_cnt_q     <= 16'd0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            good_run_q     <= good_run_d;
            period_q       <= period_d;
            period_valid_q <= period_valid_d;
            period_err_q   <= period_err_d;
            lost_q         <= lost_d;
            locked_q       <= locked_d;
            edge_cnt_q     <= edge_cnt_d;
        end
    end

    assign period       = period_q;
    assign period_valid = period_valid_q;
    assign period_err   = period_err_q;
    assign lost         = lost_q;
    assign locked       = locked_q;
    assign edge_cnt     = edge_cnt_q;

endmodule

// File: tb/tb_pulse_monitor.sv
// Bench for pulse_monitor (delay=3, tol=0, cnt_w=8). A timestamp-based
// reference model predicts every output each cycle; directed sequences are
// followed by randomized pulse trains and random resets.

module tb_pulse_monitor;

    localparam int DELAY = 3;
    localparam int TOL   = 0;
    localparam int CW    = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          pulse_in;
    logic [CW-1:0] period;
    logic          period_valid;
    logic          period_err;
    logic          lost;
    logic          locked;
    logic [15:0]   edge_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: remembers when the last edge happened and whether the
    // interval since then is a measurable one.
    bit      m_prev     = 1'b0;
    longint  m_t        = 0;
    longint  m_last_t   = 0;
    bit      m_tracking = 1'b0;
    int      m_period   = 0;
    bit      m_valid    = 1'b0;
    bit      m_err      = 1'b0;
    bit      m_lost     = 1'b0;
    int      m_run      = 0;
    int      m_edges    = 0;

    always #5 clk = ~clk;

    pulse_monitor #(.delay(DELAY), .tol(TOL), .cnt_w(CW)) dut (
        .clk          (clk),
        .reset        (reset),
        .pulse_in     (pulse_in),
        .period       (period),
        .period_valid (period_valid),
        .period_err   (period_err),
        .lost         (lost),
        .locked       (locked),
        .edge_cnt     (edge_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s at cycle %0d: observed %0h, expected %0h", tag, m_t, obs, exp);
        end
    endtask

    task automatic model_update(input bit v, input bit r);
        bit     edge_seen;
        longint iv;
        longint dev;
        edge_seen = v && !m_prev;
        if (r) begin
            m_tracking = 1'b0;
            m_period   = 0;
            m_valid    = 1'b0;
            m_err      = 1'b0;
            m_lost     = 1'b0;
            m_run      = 0;
            m_edges    = 0;
        end else begin
            m_valid = 1'b0;
            if (edge_seen) begin
                if (m_edges < 65535) m_edges++;
                if (m_tracking) begin
                    iv       = m_t - m_last_t;
                    m_period = int'(iv);
                    m_valid  = 1'b1;
                    dev      = (iv > DELAY) ? iv - DELAY : DELAY - iv;
                    m_err    = (dev > TOL);
                    if (m_err) m_run = 0;
                    else if (m_run < 4) m_run++;
                end
                m_lost     = 1'b0;
                m_tracking = 1'b1;
                m_last_t   = m_t;
            end else if (m_tracking && (m_t - m_last_t == 2 * DELAY)) begin
                m_lost     = 1'b1;
                m_tracking = 1'b0;
                m_run      = 0;
            end
        end
        m_prev = v;
        m_t++;
    endtask

    task automatic step(input bit v, input bit r);
        pulse_in = v;
        reset    = r;
        @(posedge clk);
        model_update(v, r);
        #1;
        check("period",       32'(period),       32'(m_period));
        check("period_valid", 32'(period_valid), 32'(m_valid));
        check("period_err",   32'(period_err),   32'(m_err));
        check("lost",         32'(lost),         32'(m_lost));
        check("locked",       32'(locked),       32'(m_run == 4));
        check("edge_cnt",     32'(edge_cnt),     32'(m_edges));
    endtask

    task automatic pulse_train(input int gap, input int width, input int n);
        for (int k = 0; k < n; k++) begin
            for (int i = 0; i < gap; i++) begin
                step(i < width, 1'b0);
            end
        end
    endtask

    initial begin
        int sel;
        int gap;
        int width;

        pulse_in = 1'b0;
        reset    = 1'b1;

        // Reset state.
        repeat (3) step(1'b0, 1'b1);
        check("reset_edge_cnt", 32'(edge_cnt), 32'd0);
        step(1'b0, 1'b0);

        // Regular stream at nominal delay: lock after the fifth edge.
        pulse_train(3, 1, 6);
        check("lock_after_train", 32'(locked), 32'd1);
        check("period_nominal",   32'(period), 32'd3);

        // One long interval breaks lock, four good periods restore it.
        pulse_train(4, 1, 1);
        pulse_train(3, 1, 6);
        check("relock", 32'(locked), 32'd1);

        // Stream stops: timeout, then recovery without a period.
        step(1'b1, 1'b0);
        repeat (10) step(1'b0, 1'b0);
        check("lost_after_gap", 32'(lost), 32'd1);
        pulse_train(3, 1, 3);

        // Interval exactly 2*delay is measured, not a timeout.
        pulse_train(6, 1, 1);
        step(1'b1, 1'b0);
        check("period_2delay", 32'(period), 32'd6);
        check("err_2delay",    32'(period_err), 32'd1);
        check("no_lost_2delay", 32'(lost), 32'd0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);

        // Interval 2*delay+1 times out.
        pulse_train(7, 1, 2);

        // Reset mid-measurement with the input held high through release.
        pulse_train(3, 1, 2);
        step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        repeat (5) step(1'b1, 1'b0);
        check("held_high_no_edge", 32'(edge_cnt), 32'd0);
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);

        // Input stuck high after one rise.
        step(1'b0, 1'b0);
        repeat (12) step(1'b1, 1'b0);
        check("stuck_high_lost", 32'(lost), 32'd1);
        step(1'b0, 1'b0);

        // Randomized pulse trains with occasional reset.
        for (int n = 0; n < 600; n++) begin
            sel = $urandom_range(0, 9);
            if (sel < 6)       gap = 3;
            else if (sel == 6) gap = 2;
            else if (sel == 7) gap = 4;
            else if (sel == 8) gap = $urandom_range(6, 7);
            else               gap = $urandom_range(1, 12);
            width = $urandom_range(1, gap);
            if ($urandom_range(0, 39) == 0) begin
                step(1'($urandom_range(0, 1)), 1'b1);
            end
            pulse_train(gap, width, 1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pulse_monitor.md
PULSE_MONITOR -- requirements
Module: pulse_monitor

Interface
REQ-001 Parameter delay, default 3: expected number of clk cycles between consecutive rising edges of pulse_in; legal range 1..(2^(cnt_w-1)-1).
REQ-002 Parameter tol, default 0: allowed absolute deviation of a measured period from delay.
REQ-003 Parameter cnt_w, default 8: width of the interval counter and of the period output.
REQ-004 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 Port reset  input  1  synchronous, active-high reset.
REQ-006 Port pulse_in  input  1  monitored pulse stream, synchronous to clk.
REQ-007 Port period  output  cnt_w  last measured edge-to-edge interval in cycles.
REQ-008 Port period_valid  output  1  one-cycle strobe: period updated.
REQ-009 Port period_err  output  1  last measured period out of tolerance; updates with period_valid.
REQ-010 Port lost  output  1  timeout flag: no edge within 2*delay cycles.
REQ-011 Port locked  output  1  stream in tolerance for 4 consecutive periods.
REQ-012 Port edge_cnt  output  16  rising edges seen since reset, saturating.

Function
REQ-013 Edge: a cycle with pulse_in=1 and the registered previous pulse_in (pulse_q)=0; pulse_q loads pulse_in every cycle, including during reset.
REQ-014 All outputs registered; an edge at cycle t affects outputs from cycle t+1.
REQ-015 FSM states: IDLE, MEASURE, LOST.
REQ-016 IDLE: edge -> MEASURE, cnt<=1; no period_valid.
REQ-017 MEASURE, no edge: cnt<=cnt+1, saturating at 2^cnt_w-1; cnt equals cycles elapsed since last edge.
REQ-018 MEASURE, edge: period<=cnt, period_valid=1 for one cycle, period_err<=(|cnt-delay|>tol), cnt<=1, stay MEASURE.
REQ-019 MEASURE, no edge and cnt==2*delay: -> LOST, lost<=1, locked<=0, good_run<=0, period unchanged.
REQ-020 Edge in the same cycle that cnt==2*delay: edge wins; period=2*delay is measured per REQ-018, no LOST.
REQ-021 LOST: lost held 1; edge -> MEASURE, cnt<=1, lost<=0, no period_valid (interval invalid).
REQ-022 good_run (3-bit): +1 on each in-tolerance period, saturating at 4; cleared on out-of-tolerance period or entry to LOST.
REQ-023 locked=1 while good_run==4; drops the cycle after an error or entry to LOST.
REQ-024 edge_cnt increments on every edge in every state, saturating at 16'hFFFF.
REQ-025 Difference |cnt-delay| computed at cnt_w+1 bits; no wrap.

Reset
REQ-026 reset=1 at a clk edge: state<=IDLE, cnt<=0, good_run<=0, period<=0, period_valid<=0, period_err<=0, lost<=0, locked<=0, edge_cnt<=0; pulse_q<=pulse_in.
REQ-027 Reset overrides all other events in the same cycle, including mid-measurement and in LOST.
REQ-028 pulse_in held high across reset release produces no edge.

Verification (delay=3, tol=0, cnt_w=8)
REQ-029 1-cycle pulses every 3 cycles -> period_valid from 2nd edge on, period=3, period_err=0; locked=1 the cycle after the 5th edge; edge_cnt tracks edges.
REQ-030 Locked stream, one interval of 4 -> period=4, period_err=1, locked=0 next cycle; relock after 4 more good periods.
REQ-031 Edge at t, pulse_in=0 thereafter -> lost=1 from t+7, locked=0; next edge -> lost=0, no period_valid; following edge at +3 -> period=3 valid.
REQ-032 Edge at t, next edge at t+6 -> period=6, period_err=1, lost stays 0.
REQ-033 Reset asserted mid-MEASURE with pulse_in held high through release -> all outputs 0 the cycle after reset, state IDLE, edge_cnt stays 0 until pulse_in falls and rises again.
REQ-034 pulse_in constant high after one rise -> edge_cnt=1, lost=1 at 2*delay+1 cycles after the rise, no further period_valid.
